// File: rtl/uart_xmt_datapath.sv
// UART transmit datapath: data register, frame shift register and bit counter.
// Control strobes come from an external sequencer; clear > shift > start > load.
module uart_xmt_datapath #(
  parameter int word_size = 8,
  parameter int BC_max    = word_size + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [word_size-1:0]         data_bus,
  input  logic                         Load_XMT_DR,
  input  logic                         Load_XMT_shfreg,
  input  logic                         start,
  input  logic                         shift,
  input  logic                         clear,
  output logic                         serial_out,
  output logic                         BC_lt_BCMax,
  output logic [word_size-1:0]         XMT_datareg,
  output logic [$clog2(BC_max+1)-1:0]  bit_count,
  output logic                         tx_busy
);
  localparam int BCW = $clog2(BC_max + 1);
  localparam logic [BCW-1:0] BC_MAX_C = BCW'(BC_max);

  logic [word_size-1:0] datareg_q, datareg_d;
  logic [word_size:0]   shftreg_q, shftreg_d;
  logic [BCW-1:0]       bit_count_q, bit_count_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 bc_lt;

  assign bc_lt = (bit_count_q < BC_MAX_C);

  always_comb begin
    datareg_d   = Load_XMT_DR ? data_bus : datareg_q;
    shftreg_d   = shftreg_q;
    bit_count_d = bit_count_q;
    tx_busy_d   = tx_busy_q;
    if (clear) begin
      shftreg_d   = '1;
      bit_count_d = '0;
      tx_busy_d   = 1'b0;
    end else if (shift) begin
      // Fill with ones so the stop bit and idle level trail the data.
      shftreg_d = {1'b1, shftreg_q[word_size:1]};
      if (bc_lt) bit_count_d = bit_count_q + BCW'(1);
    end else if (start) begin
      shftreg_d = {shftreg_q[word_size:1], 1'b0};
      tx_busy_d = 1'b1;
    end else if (Load_XMT_shfreg) begin
      shftreg_d = {datareg_q, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      datareg_q   <= '0;
      shftreg_q   <= '1;
      bit_count_q <= '0;
      tx_busy_q   <= 1'b0;
    end else begin
      datareg_q   <= datareg_d;
      shftreg_q   <= shftreg_d;
      bit_count_q <= bit_count_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  assign serial_out  = shftreg_q[0];
  assign BC_lt_BCMax = bc_lt;
  assign XMT_datareg = datareg_q;
  assign bit_count   = bit_count_q;
  assign tx_busy     = tx_busy_q;
endmodule

// File: tb/tb_uart_xmt_datapath.sv
// Bench for uart_xmt_datapath: directed frames plus random frames against a
// frame-level model (pending byte, position in frame, saturating count).
module tb_uart_xmt_datapath;
  localparam int WS  = 8;
  localparam int BCM = WS + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WS-1:0] data_bus = '0;
  logic          Load_XMT_DR = 1'b0, Load_XMT_shfreg = 1'b0;
  logic          start = 1'b0, shift = 1'b0, clear = 1'b0;
  logic          serial_out, BC_lt_BCMax, tx_busy;
  logic [WS-1:0] XMT_datareg;
  logic [3:0]    bit_count;

  uart_xmt_datapath #(.word_size(WS), .BC_max(BCM)) dut (
    .clk(clk), .rst_n(rst_n), .data_bus(data_bus),
    .Load_XMT_DR(Load_XMT_DR), .Load_XMT_shfreg(Load_XMT_shfreg),
    .start(start), .shift(shift), .clear(clear),
    .serial_out(serial_out), .BC_lt_BCMax(BC_lt_BCMax),
    .XMT_datareg(XMT_datareg), .bit_count(bit_count), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Frame-level model: the byte that a start would send, where we are in it.
  logic [WS-1:0] m_dr, m_pending;
  bit            m_started, m_busy;
  int            m_pos, m_cnt;

  function automatic logic exp_line();
    if (!m_started)     return 1'b1;
    if (m_pos == 0)     return 1'b0;
    if (m_pos <= WS)    return m_pending[m_pos-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_dr = '0; m_pending = '1; m_started = 0; m_busy = 0; m_pos = 0; m_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".serial"}, 32'(serial_out), 32'(exp_line()));
    chk({tag, ".count"},  32'(bit_count), 32'(m_cnt));
    chk({tag, ".bclt"},   32'(BC_lt_BCMax), 32'(m_cnt < BCM));
    chk({tag, ".busy"},   32'(tx_busy), 32'(m_busy));
    chk({tag, ".dreg"},   32'(XMT_datareg), 32'(m_dr));
  endtask

  task automatic step(input string tag, input bit ldr, input logic [WS-1:0] d,
                      input bit lsh, input bit st, input bit sh, input bit cl);
    logic [WS-1:0] old_dr;
    data_bus = d; Load_XMT_DR = ldr; Load_XMT_shfreg = lsh;
    start = st; shift = sh; clear = cl;
    @(posedge clk); #1;
    Load_XMT_DR = 0; Load_XMT_shfreg = 0; start = 0; shift = 0; clear = 0;
    old_dr = m_dr;
    if (ldr) m_dr = d;
    if (cl) begin
      m_cnt = 0; m_busy = 0; m_started = 0; m_pending = '1;
    end else if (sh) begin
      if (m_cnt < BCM) m_cnt++;
      m_pos++;
    end else if (st) begin
      m_started = 1; m_pos = 0; m_busy = 1;
    end else if (lsh) begin
      m_pending = old_dr;
    end
    check_all(tag);
  endtask

  task automatic prep(input string tag, input logic [WS-1:0] d);
    step({tag, ".ldr"}, 1, d, 0, 0, 0, 0);
    step({tag, ".lsh"}, 0, '0, 1, 0, 0, 0);
    step({tag, ".st"},  0, '0, 0, 1, 0, 0);
  endtask

  initial begin
    logic [9:0] a5_line;
    logic [WS-1:0] d;
    model_reset();
    #12;
    check_all("reset");
    #1 rst_n = 1'b1;

    // A5 frame with literal expected line sequence, start bit first.
    a5_line = 10'b11_1010_0101 << 1;
    a5_line[0] = 1'b0;
    prep("a5", 8'hA5);
    chk("a5.bit0", 32'(serial_out), 32'(a5_line[0]));
    for (int i = 1; i <= 9; i++) begin
      step("a5.sh", 0, '0, 0, 0, 1, 0);
      chk("a5.lit", 32'(serial_out), 32'(a5_line[i]));
    end
    chk("a5.bclt_low", 32'(BC_lt_BCMax), 32'(0));
    step("a5.idle", 0, '0, 0, 0, 0, 0);
    step("a5.sat", 0, '0, 0, 0, 1, 0);
    chk("sat.count", 32'(bit_count), 32'(9));
    chk("sat.line", 32'(serial_out), 32'(1));
    step("a5.clr", 0, '0, 0, 0, 0, 1);
    chk("a5.clr_busy", 32'(tx_busy), 32'(0));

    // Clear and shift on the same edge at count 5.
    prep("cs", 8'h5A);
    for (int i = 0; i < 5; i++) step("cs.sh", 0, '0, 0, 0, 1, 0);
    step("cs.both", 0, '0, 0, 0, 1, 1);
    chk("cs.count", 32'(bit_count), 32'(0));
    chk("cs.line", 32'(serial_out), 32'(1));

    // Data register reload during a frame of zeros.
    prep("ind", 8'h00);
    for (int i = 0; i < 9; i++) step("ind.sh", (i % 3) == 1, 8'hFF, 0, 0, 1, 0);
    chk("ind.dreg", 32'(XMT_datareg), 32'hFF);
    step("ind.clr", 0, '0, 0, 0, 0, 1);

    // start and Load_XMT_shfreg together: start wins on a cleared register.
    step("pri.ldr", 1, 8'h00, 0, 0, 0, 0);
    step("pri.both", 0, '0, 1, 1, 0, 0);
    chk("pri.line", 32'(serial_out), 32'(0));
    step("pri.sh", 0, '0, 0, 0, 1, 0);
    step("pri.clr", 0, '0, 0, 0, 0, 1);

    // Asynchronous reset mid-frame.
    prep("rst", 8'h3C);
    for (int i = 0; i < 4; i++) step("rst.sh", 0, '0, 0, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.line", 32'(serial_out), 32'(1));
    chk("rst.count", 32'(bit_count), 32'(0));
    chk("rst.dreg", 32'(XMT_datareg), 32'(0));
    chk("rst.bclt", 32'(BC_lt_BCMax), 32'(1));
    #2 rst_n = 1'b1;
    step("rst.first", 1, 8'h81, 0, 0, 0, 0);

    // Random frames with idle gaps and data register reloads mid-frame.
    for (int f = 0; f < 20; f++) begin
      d = WS'($urandom);
      prep("rnd", d);
      for (int i = 0; i < 9 + int'($urandom_range(0, 2)); i++) begin
        if ($urandom_range(0, 3) == 0) step("rnd.idle", 0, '0, 0, 0, 0, 0);
        step("rnd.sh", $urandom_range(0, 2) == 0, WS'($urandom), 0, 0, 1, 0);
      end
      step("rnd.clr", 0, '0, 0, 0, 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_xmt_datapath.md
UART_XMT_DATAPATH -- requirements
Module: uart_xmt_datapath

Interface
REQ-001 The block SHALL have parameter word_size, default 8, giving the number of data bits per frame.
REQ-002 The block SHALL have parameter BC_max, default word_size+1, giving the number of shifts per frame (data bits plus stop bit).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 data_bus  input  word_size  parallel byte to transmit.
REQ-006 Load_XMT_DR  input  1  capture data_bus into the data register.
REQ-007 Load_XMT_shfreg  input  1  copy the data register into the shift register.
REQ-008 start  input  1  drive the start bit onto the line.
REQ-009 shift  input  1  advance the frame by one bit and increment the bit count.
REQ-010 clear  input  1  end of frame; zero the bit count.
REQ-011 serial_out  output  1  UART line, idle high, registered.
REQ-012 BC_lt_BCMax  output  1  high while bit_count < BC_max.
REQ-013 XMT_datareg  output  word_size  current data register contents.
REQ-014 bit_count  output  ceil(log2(BC_max+1))  shifts taken in the current frame.
REQ-015 tx_busy  output  1  high from start until clear.

Function
REQ-016 XMT_datareg SHALL load data_bus on a clock edge with Load_XMT_DR=1, and otherwise hold.
REQ-017 XMT_datareg loading SHALL be independent of every other control and of the transmit state.
REQ-018 The shift register XMT_shftreg (word_size+1 bits) SHALL update under priority clear > shift > start > Load_XMT_shfreg; only the winning control acts on it.
REQ-019 Load_XMT_shfreg SHALL set XMT_shftreg to {XMT_datareg, 1'b1}, so the line stays high.
REQ-020 start SHALL set XMT_shftreg[0] to 0 (start bit), hold the upper bits, and set tx_busy to 1.
REQ-021 shift SHALL set XMT_shftreg to {1'b1, XMT_shftreg[word_size:1]}, filling with 1s so the stop bit and idle level follow the data.
REQ-022 shift SHALL increment bit_count by 1 when bit_count < BC_max, and hold it at BC_max otherwise (saturate, no wrap).
REQ-023 clear SHALL set bit_count to 0, set XMT_shftreg to all ones, and set tx_busy to 0.
REQ-024 clear SHALL win over shift on the same edge, so no increment occurs on that edge.
REQ-025 serial_out SHALL equal XMT_shftreg[0], taken directly from the flop with no combinational path from the inputs.
REQ-026 BC_lt_BCMax SHALL be combinational from bit_count only.
REQ-027 Frame order on serial_out, one bit per shift: start 0, data LSB first, then stop 1.
REQ-028 Latency: each control SHALL take effect on serial_out and bit_count at the first rising edge after it is sampled high.
REQ-029 With no control asserted, all registers SHALL hold.

Reset
REQ-030 With rst_n=0, the block SHALL asynchronously set XMT_datareg=0, XMT_shftreg to all ones, bit_count=0 and tx_busy=0.
REQ-031 During reset, serial_out SHALL be 1 and BC_lt_BCMax SHALL be 1.
REQ-032 A reset asserted mid-frame SHALL abort the frame immediately, with the line returning to 1 without waiting for a clock.
REQ-033 After rst_n deasserts, the block SHALL accept controls from the first rising edge.

Verification
REQ-034 Full frame: data_bus=8'hA5, Load_XMT_DR, Load_XMT_shfreg, start, then 9 shifts -> serial_out 0,1,0,1,0,0,1,0,1,1; BC_lt_BCMax falls after the 9th shift; clear then gives bit_count=0 and tx_busy=0.
REQ-035 Simultaneous clear and shift at bit_count=5 -> bit_count=0, serial_out=1.
REQ-036 Saturation: an extra shift at bit_count=9 -> bit_count stays 9 and serial_out stays 1.
REQ-037 Mid-frame reset: rst_n low after 4 shifts of 8'h3C -> serial_out=1, bit_count=0 and XMT_datareg=0 before the next clock edge.
REQ-038 Load_XMT_DR with 8'hFF during shifts of 8'h00 -> the frame in flight is unaffected; XMT_datareg=8'hFF.
REQ-039 Priority: start and Load_XMT_shfreg asserted on the same edge -> only start acts, and serial_out=0.
